// File: rtl/fc_event_dispatcher.sv
// fc_event_dispatcher: per-source saturating event counters with a round-robin
// grant that feeds one event ID per cycle into the FC event FIFO port.
`default_nettype none

module fc_event_dispatcher #(
   parameter int NB_EVENTS      = 16,
   parameter int EVENT_ID_WIDTH = 8,
   parameter int CNT_WIDTH      = 2,
   parameter int ID_BASE        = 0,
   localparam int IDX_WIDTH     = $clog2(NB_EVENTS)
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic [NB_EVENTS-1:0]      event_i,
   input  logic                      enable_i,
   output logic                      fifo_valid_o,
   input  logic                      fifo_fulln_i,
   output logic [EVENT_ID_WIDTH-1:0] fifo_data_o,
   output logic                      overflow_o,
   output logic [IDX_WIDTH-1:0]      overflow_id_o,
   output logic                      busy_o
);

   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

   logic [CNT_WIDTH-1:0] cnt [NB_EVENTS];
   logic [NB_EVENTS-1:0] nonzero;
   logic [NB_EVENTS-1:0] dec;
   logic [NB_EVENTS-1:0] drop;
   logic [IDX_WIDTH-1:0] rr_ptr;
   logic [IDX_WIDTH-1:0] grant_idx;
   logic [IDX_WIDTH-1:0] lowest_drop;
   logic                 any_pending;
   logic                 load;

   // Adds two in-range quantities and folds the result back into 0..NB_EVENTS-1.
   function automatic logic [IDX_WIDTH-1:0] wrap_idx(input int value);
      int folded;
      folded = (value >= NB_EVENTS) ? value - NB_EVENTS : value;
      return IDX_WIDTH'(folded);
   endfunction

   always_comb begin
      for (int k = 0; k < NB_EVENTS; k++) begin
         nonzero[k] = (cnt[k] != '0);
      end
   end

   assign any_pending = |nonzero;
   assign load        = enable_i && (!fifo_valid_o || fifo_fulln_i) && any_pending;
   assign busy_o      = any_pending || fifo_valid_o;

   // First nonzero counter at or above the pointer, wrapping past the top.
   always_comb begin
      logic                 found;
      logic [IDX_WIDTH-1:0] idx;
      found     = 1'b0;
      grant_idx = '0;
      idx       = '0;
      for (int i = 0; i < NB_EVENTS; i++) begin
         idx = wrap_idx(int'(rr_ptr) + i);
         if (!found && nonzero[idx]) begin
            found     = 1'b1;
            grant_idx = idx;
         end
      end
   end

   always_comb begin
      for (int k = 0; k < NB_EVENTS; k++) begin
         dec[k]  = load && (grant_idx == IDX_WIDTH'(k));
         drop[k] = event_i[k] && !dec[k] && (cnt[k] == CNT_MAX);
      end
   end

   always_comb begin
      lowest_drop = '0;
      for (int k = NB_EVENTS - 1; k >= 0; k--) begin
         if (drop[k]) begin
            lowest_drop = IDX_WIDTH'(k);
         end
      end
   end

   generate
      for (genvar k = 0; k < NB_EVENTS; k++) begin : g_cnt
         always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
               cnt[k] <= '0;
            end else if (event_i[k] && !dec[k]) begin
               if (cnt[k] != CNT_MAX) begin
                  cnt[k] <= cnt[k] + 1'b1;
               end
            end else if (!event_i[k] && dec[k]) begin
               cnt[k] <= cnt[k] - 1'b1;
            end
         end
      end
   endgenerate

   // Output register: a held event stays put until the FIFO accepts it.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         fifo_valid_o <= 1'b0;
         fifo_data_o  <= '0;
         rr_ptr       <= '0;
      end else if (load) begin
         fifo_valid_o <= 1'b1;
         fifo_data_o  <= EVENT_ID_WIDTH'(ID_BASE + int'(grant_idx));
         rr_ptr       <= wrap_idx(int'(grant_idx) + 1);
      end else if (fifo_valid_o && fifo_fulln_i) begin
         fifo_valid_o <= 1'b0;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         overflow_o    <= 1'b0;
         overflow_id_o <= '0;
      end else begin
         overflow_o <= |drop;
         if (|drop) begin
            overflow_id_o <= lowest_drop;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_fc_event_dispatcher.sv
// tb_fc_event_dispatcher: directed stimulus with an expected-ID queue drained by a monitor.
`default_nettype none

module tb_fc_event_dispatcher;

   localparam int N    = 16;
   localparam int W    = 8;
   localparam int CW   = 2;
   localparam int BASE = 'h20;
   localparam int IW   = $clog2(N);

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [N-1:0]  ev = '0;
   logic          en = 1'b1;
   logic          fulln = 1'b1;
   logic          valid;
   logic [W-1:0]  data;
   logic          ovf;
   logic [IW-1:0] ovf_id;
   logic          busy;

   int checks = 0;
   int passes = 0;
   int exp_q[$];

   fc_event_dispatcher #(
      .NB_EVENTS(N), .EVENT_ID_WIDTH(W), .CNT_WIDTH(CW), .ID_BASE(BASE)
   ) dut (
      .clk_i(clk), .rst_i(rst), .event_i(ev), .enable_i(en),
      .fifo_valid_o(valid), .fifo_fulln_i(fulln), .fifo_data_o(data),
      .overflow_o(ovf), .overflow_id_o(ovf_id), .busy_o(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act == req) passes++;
      else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, req, req);
   endtask

   // Monitor: every accepted transfer must match the next expected ID.
   always @(negedge clk) begin
      if (!rst && valid && fulln) begin
         if (exp_q.size() == 0) begin
            checks++;
            $display("FAIL unexpected_transfer: got id 0x%0h expected no transfer", data);
         end else begin
            chk("fifo_data", int'(data), exp_q.pop_front());
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input string name);
      for (int i = 0; i < 300; i++) begin
         if (exp_q.size() == 0 && !busy) break;
         tick();
      end
      chk(name, int'(exp_q.size() == 0 && !busy), 1);
   endtask

   initial begin
      // Reset state
      repeat (3) tick();
      chk("rst_valid", int'(valid), 0);
      chk("rst_data", int'(data), 0);
      chk("rst_ovf", int'(ovf), 0);
      chk("rst_ovf_id", int'(ovf_id), 0);
      chk("rst_busy", int'(busy), 0);
      rst = 1'b0;
      tick();

      // Single pulse on source 3: valid two cycles later, one transfer
      exp_q.push_back(BASE + 3);
      ev = 16'h0008;
      tick();
      ev = '0;
      tick();
      chk("t1_valid_c2", int'(valid), 1);
      chk("t1_data_c2", int'(data), BASE + 3);
      tick();
      chk("t1_valid_c3", int'(valid), 0);
      chk("t1_busy_c3", int'(busy), 0);

      // Stall: source 5 held stable through four not-full cycles
      exp_q.push_back(BASE + 5);
      fulln = 1'b0;
      ev = 16'h0020;
      tick();
      ev = '0;
      tick();
      for (int c = 2; c < 6; c++) begin
         chk("t2_stall_valid", int'(valid), 1);
         chk("t2_stall_data", int'(data), BASE + 5);
         tick();
      end
      fulln = 1'b1;
      tick();
      chk("t2_valid_after", int'(valid), 0);
      chk("t2_single_transfer", exp_q.size(), 0);

      // Simultaneous 2 and 5 from pointer 6, then 1 and 7 from pointer 6
      exp_q.push_back(BASE + 2);
      exp_q.push_back(BASE + 5);
      ev = 16'h0024;
      tick();
      ev = '0;
      drain("t3a_drain");
      exp_q.push_back(BASE + 7);
      exp_q.push_back(BASE + 1);
      ev = 16'h0082;
      tick();
      ev = '0;
      drain("t3b_drain");

      // Saturation on source 1 with the FIFO full
      fulln = 1'b0;
      for (int i = 0; i < 4; i++) exp_q.push_back(BASE + 1);
      for (int c = 0; c < 9; c++) begin
         if (c == 5 || c == 6) begin
            chk("sat_ovf_pulse", int'(ovf), 1);
            chk("sat_ovf_id", int'(ovf_id), 1);
         end else if (c >= 1) begin
            chk("sat_ovf_quiet", int'(ovf), 0);
         end
         ev = (c <= 5) ? 16'h0002 : 16'h0000;
         tick();
      end
      chk("sat_valid", int'(valid), 1);
      chk("sat_data", int'(data), BASE + 1);
      fulln = 1'b1;
      drain("sat_drain");

      // Fairness: sources 0 and 1 every cycle must alternate strictly
      for (int i = 0; i < 12; i++) begin
         exp_q.push_back(BASE + 0);
         exp_q.push_back(BASE + 1);
      end
      exp_q.push_back(BASE + 0);
      for (int c = 0; c < 20; c++) begin
         ev = 16'h0003;
         tick();
      end
      ev = '0;
      drain("fair_drain");

      // enable low blocks loading; raising it releases three events
      en = 1'b0;
      for (int c = 0; c < 3; c++) begin
         ev = 16'h0010;
         tick();
      end
      ev = '0;
      repeat (3) tick();
      chk("en_low_valid", int'(valid), 0);
      chk("en_low_busy", int'(busy), 1);
      for (int i = 0; i < 3; i++) exp_q.push_back(BASE + 4);
      en = 1'b1;
      drain("en_drain");

      // Asynchronous reset while an event is held against a full FIFO
      fulln = 1'b0;
      ev = 16'h0240;
      tick();
      ev = 16'h0200;
      tick();
      ev = '0;
      chk("rst_mid_valid_before", int'(valid), 1);
      #2;
      rst = 1'b1;
      #1;
      chk("rst_mid_valid", int'(valid), 0);
      chk("rst_mid_busy", int'(busy), 0);
      chk("rst_mid_data", int'(data), 0);
      tick();
      tick();
      rst = 1'b0;
      fulln = 1'b1;
      repeat (10) tick();
      chk("rst_after_valid", int'(valid), 0);
      chk("rst_after_busy", int'(busy), 0);

      chk("scoreboard_empty", exp_q.size(), 0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

`default_nettype wire
